// File: rtl/poly_mixer_pkg.sv
// Shared types and width helpers for the polyphonic voice mixer.
package poly_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int OVERRUN_W = 16;

  // Accumulator headroom: one extra bit per doubling of the voice count.
  function automatic int acc_w(input int audio_w, input int num_voices);
    return audio_w + $clog2(num_voices);
  endfunction

  function automatic int cnt_w(input int num_voices);
    return $clog2(num_voices + 1);
  endfunction

endpackage

// File: rtl/poly_voice_mixer_sat_shift.sv
// Combinational arithmetic right shift (floor) followed by signed saturation
// from IN_W bits down to OUT_W bits.
module sat_shift #(
  parameter int IN_W  = 35,
  parameter int OUT_W = 24,
  parameter int SH_W  = 8
) (
  input  logic [IN_W-1:0]  din,
  input  logic [SH_W-1:0]  shamt,
  output logic [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0] shifted;

  always_comb begin
    shifted = $signed(din) >>> shamt;
    if (shifted > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/poly_voice_mixer.sv
// Polyphonic mixer: snapshots all voices, sums the active ones one per clock,
// then shifts/saturates onto a valid/ready stream. Option: POLY_MIXER_AUTOSCALE_EN.
//
// Handshakes: a snapshot is taken on a cycle with in_valid & in_ready; a result
// is consumed on a cycle with out_valid & out_ready. Neither valid/ready depends
// combinationally on the partner's signal, and mix_out/active_count stay stable
// while out_valid is high.
module poly_voice_mixer
  import poly_mixer_pkg::*;
#(
  parameter int NUM_VOICES  = 8,
  parameter int AUDIO_WIDTH = 32,
  parameter int OUT_WIDTH   = 24,
  parameter int SHIFT       = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_VOICES*AUDIO_WIDTH-1:0] voices_in,
  input  logic [NUM_VOICES-1:0]             note_on,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [OUT_WIDTH-1:0]              mix_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [cnt_w(NUM_VOICES)-1:0]      active_count,
  output logic [OVERRUN_W-1:0]              overrun_count
);

  localparam int ACC_W = acc_w(AUDIO_WIDTH, NUM_VOICES);
  localparam int CNT_W = cnt_w(NUM_VOICES);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int SH_W  = 8;

  state_t state, state_nx;

  logic [NUM_VOICES*AUDIO_WIDTH-1:0] snap_voices;
  logic [NUM_VOICES-1:0]             snap_mask;
  logic signed [ACC_W-1:0]           acc;
  logic [IDX_W-1:0]                  idx;
  logic [AUDIO_WIDTH-1:0]            cur_voice;
  logic                              cur_on;
  logic [CNT_W-1:0]                  pop;
  logic [SH_W-1:0]                   shamt;
  logic [OUT_WIDTH-1:0]              scaled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ACCUM;
      end
      ACCUM: begin
        if (idx == IDX_W'(NUM_VOICES - 1)) state_nx = SCALE;
      end
      SCALE: state_nx = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Voice select mux; idx never exceeds NUM_VOICES-1 so unused codes give zero.
  always_comb begin
    cur_voice = '0;
    cur_on    = 1'b0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_voice = snap_voices[k*AUDIO_WIDTH +: AUDIO_WIDTH];
        cur_on    = snap_mask[k];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      pop = pop + CNT_W'(snap_mask[k]);
    end
  end

`ifdef POLY_MIXER_AUTOSCALE_EN
  logic [SH_W-1:0] log_pop;

  // ceil(log2(max(pop,1))): the largest c with pop > 2^(c-1).
  always_comb begin
    log_pop = '0;
    for (int c = 1; c <= CNT_W; c++) begin
      if (int'(pop) > (1 << (c - 1))) log_pop = SH_W'(c);
    end
  end

  assign shamt = SH_W'(SHIFT) + log_pop;
`else
  assign shamt = SH_W'(SHIFT);
`endif

  sat_shift #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_WIDTH),
    .SH_W  (SH_W)
  ) u_sat_shift (
    .din   (acc),
    .shamt (shamt),
    .dout  (scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_voices  <= '0;
      snap_mask    <= '0;
      acc          <= '0;
      idx          <= '0;
      mix_out      <= '0;
      active_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            snap_voices <= voices_in;
            snap_mask   <= note_on;
            acc         <= '0;
            idx         <= '0;
          end
        end
        ACCUM: begin
          if (cur_on) begin
            acc <= acc + {{(ACC_W-AUDIO_WIDTH){cur_voice[AUDIO_WIDTH-1]}}, cur_voice};
          end
          idx <= idx + IDX_W'(1);
        end
        SCALE: begin
          mix_out      <= scaled;
          active_count <= pop;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_count <= '0;
    end else if (in_valid && !in_ready && (overrun_count != {OVERRUN_W{1'b1}})) begin
      overrun_count <= overrun_count + OVERRUN_W'(1);
    end
  end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed bench for poly_voice_mixer with a transaction-level reference model.
module tb_poly_voice_mixer;

  localparam int NV    = 8;
  localparam int AW    = 32;
  localparam int OW    = 24;
  localparam int SHIFT = 8;
  localparam int CW    = 4;
  localparam int EW    = CW + OW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    vv [NV];
  logic [NV*AW-1:0] voices_in;
  logic [NV-1:0]    note_on = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OW-1:0]    mix_out;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    active_count;
  logic [15:0]      overrun_count;

  always_comb begin
    voices_in = '0;
    for (int k = 0; k < NV; k++) voices_in[k*AW +: AW] = vv[k];
  end

  poly_voice_mixer #(
    .NUM_VOICES  (NV),
    .AUDIO_WIDTH (AW),
    .OUT_WIDTH   (OW),
    .SHIFT       (SHIFT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .voices_in     (voices_in),
    .note_on       (note_on),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mix_out       (mix_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .active_count  (active_count),
    .overrun_count (overrun_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mix = floor(sum of active voices / 2^shift), clamped to the OW-bit range.
  function automatic logic [EW-1:0] model_mix(input logic [NV-1:0] m);
    longint s, d, q;
    int n, sh;
    s = 0;
    n = 0;
    for (int k = 0; k < NV; k++) begin
      if (m[k]) begin
        s += longint'($signed(vv[k]));
        n++;
      end
    end
    sh = SHIFT;
`ifdef POLY_MIXER_AUTOSCALE_EN
    begin
      int c;
      c = 0;
      while ((1 << c) < n) c++;
      sh += c;
    end
`endif
    d = longint'(1) << sh;
    if (s >= 0) q = s / d;
    else        q = -((-s + d - 1) / d);
    if (q > 8388607)       q = 8388607;
    else if (q < -8388608) q = -8388608;
    return {CW'(n), OW'(q)};
  endfunction

  logic [EW-1:0] exp_q [$];
  bit     busy = 0;
  longint e = 0;       // rising edges seen
  longint a = 0;       // edge number of the last accept
  int     ovr = 0;
  bit     prev_valid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0;
      ovr = 0;
      exp_q.delete();
    end else begin
      bit ov;
      ov = busy && (e >= a + NV + 1);
      if (in_valid && busy) begin
        if (ovr < 16'hFFFF) ovr++;
      end else if (in_valid) begin
        busy = 1;
        a = e + 1;
        exp_q.push_back(model_mix(note_on));
      end
      if (ov && out_ready) begin
        busy = 0;
        void'(exp_q.pop_front());
      end
      e++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      bit ov;
      ov = busy && (e >= a + NV + 1);
      check("in_ready", in_ready, !busy);
      check("out_valid", out_valid, ov);
      check("overrun_count", overrun_count, ovr);
      if (out_valid && !prev_valid && busy) check("latency", e + 1 - a, NV + 2);
      if (ov && exp_q.size() > 0) begin
        check("mix_out_model", $signed(mix_out), $signed(exp_q[0][OW-1:0]));
        check("active_count_model", active_count, exp_q[0][EW-1:OW]);
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_all(input logic [AW-1:0] val, input logic [NV-1:0] m);
    for (int k = 0; k < NV; k++) vv[k] = val;
    note_on = m;
  endtask

  task automatic scramble();
    for (int k = 0; k < NV; k++) vv[k] = $urandom;
    note_on = NV'($urandom_range(0, 255));
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: out_valid got 0, expected 1 within 40 cycles", name);
    end
  endtask

  task automatic run_mix(input string name, input longint exp_mix, input longint exp_cnt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    wait_valid(name);
    check({name, "_mix"}, $signed(mix_out), exp_mix);
    check({name, "_cnt"}, active_count, exp_cnt);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint exp_basic, exp_neg, exp_five;
    logic [OW-1:0] held;
`ifdef POLY_MIXER_AUTOSCALE_EN
    exp_basic = 65536;
    exp_neg   = -2;
    exp_five  = 40960;
`else
    exp_basic = 524288;
    exp_neg   = -4;
    exp_five  = 327680;
`endif
    set_all('0, '0);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_mix_out", mix_out, 0);
    check("reset_active_count", active_count, 0);
    check("reset_overrun", overrun_count, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    set_all(32'h0100_0000, 8'hFF);
    run_mix("basic", exp_basic, 8);

    set_all('0, 8'h05);
    vv[0] = 32'd800;
    vv[2] = -32'sd1600;
    run_mix("mask_neg", exp_neg, 2);

    set_all('0, 8'h01);
    vv[0] = 32'd800;
    vv[2] = -32'sd1600;
    run_mix("mask_one", 3, 1);

    set_all(32'h7FFF_FFFF, 8'hFF);
    run_mix("sat_max", 8388607, 8);

    set_all(32'h8000_0000, 8'hFF);
    run_mix("sat_min", -8388608, 8);

    set_all(32'h7FFF_FFFF, 8'h1F);
    for (int k = 0; k < 5; k++) vv[k] = 32'h0100_0000;
    run_mix("five", exp_five, 5);

    // Back-pressure with in_valid held high throughout.
    set_all(32'h0100_0000, 8'hFF);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    scramble();
    wait_valid("bp");
    held = mix_out;
    check("bp_mix", $signed(mix_out), exp_basic);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      scramble();
      @(negedge clk);
      check("bp_hold_stable", mix_out, held);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after_hs", in_ready, 1);
    check("bp_valid_after_hs", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_reaccepted", in_ready, 0);
    check("bp_overrun", overrun_count, 30);
    wait_valid("bp_second");
    @(posedge clk); #1;

    // Reset while idx=4.
    set_all(32'h0100_0000, 8'hFF);
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mix_out", mix_out, 0);
    check("rst_active_count", active_count, 0);
    check("rst_overrun", overrun_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int seen_valid;
      seen_valid = 0;
      repeat (20) begin
        @(negedge clk);
        if (out_valid) seen_valid++;
      end
      check("rst_no_partial", seen_valid, 0);
    end

    set_all(32'h0100_0000, 8'hFF);
    run_mix("after_reset", exp_basic, 8);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
